tipi_ti_bus_regs: RTL and testbench

- TI-99/4A-side register port of the TIPI PEB card.
- Samples the asynchronous TI expansion bus into the card clock domain and decodes memory-mapped accesses to the four TIPI registers.
- TI CPU writes to the TD/TC addresses are glitch-filtered and committed to `TD`/`TC`; these are the registers the MCU reads over the 4-bit Pi bus.
- TI CPU reads of the RD/RC addresses return the `RD`/`RC` values written by the MCU.

---
 rtl/tipi_pkg.sv | 24 ++
 rtl/tipi_sync.sv | 28 ++
 rtl/tipi_ti_bus_regs.sv | 178 +++++++++++++++++
 tb/tb_tipi_ti_bus_regs.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tipi_pkg.sv
// Shared constants and types for the TIPI TI-side register port.
package tipi_pkg;

  localparam logic [15:0] TIPI_RC_ADDR = 16'h5FF9;
  localparam logic [15:0] TIPI_RD_ADDR = 16'h5FFB;
  localparam logic [15:0] TIPI_TC_ADDR = 16'h5FFD;
  localparam logic [15:0] TIPI_TD_ADDR = 16'h5FFF;

  // Address (16) + data (8) + memen_n + we_n + dbin.
  localparam int SYNC_W = 27;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COMMIT,
    WAIT
  } wrState_t;

  typedef enum logic {
    TGT_TD,
    TGT_TC
  } target_t;

endpackage

// File: rtl/tipi_sync.sv
// Two-flop synchronizer bank bringing the asynchronous TI bus into the card clock domain.
module tipi_sync
  import tipi_pkg::*;
#(
  parameter int W = SYNC_W
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/tipi_ti_bus_regs.sv
// TI-99/4A side of the TIPI card: filtered TI writes into TD/TC and registered
// TI reads of the MCU-owned RD/RC registers.
module tipi_ti_bus_regs
  import tipi_pkg::*;
#(
  parameter logic [15:0] RC_ADDR = TIPI_RC_ADDR,
  parameter logic [15:0] RD_ADDR = TIPI_RD_ADDR,
  parameter logic [15:0] TC_ADDR = TIPI_TC_ADDR,
  parameter logic [15:0] TD_ADDR = TIPI_TD_ADDR,
  parameter int          FILTER  = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_ti_a,
  input  logic [7:0]  i_ti_d_in,
  output logic [7:0]  o_ti_d_out,
  output logic        o_ti_d_oe,
  input  logic        i_ti_memen_n,
  input  logic        i_ti_we_n,
  input  logic        i_ti_dbin,
  input  logic        i_cru_en,
  input  logic [7:0]  i_rd,
  input  logic [7:0]  i_rc,
  output logic [7:0]  o_td,
  output logic [7:0]  o_tc,
  output logic        o_td_strobe,
  output logic        o_tc_strobe
);

  localparam int CNT_W = 3;

  logic [SYNC_W-1:0] w_syncIn;
  logic [SYNC_W-1:0] w_syncOut;
  logic [15:0]       w_addr;
  logic [7:0]        w_data;
  logic              w_memen_n;
  logic              w_we_n;
  logic              w_dbin;

  logic              w_hitW;
  logic              w_hitR;
  target_t           w_addrTarget;
  logic [15:0]       w_tgtAddr;

  wrState_t          r_state;
  wrState_t          w_stateNext;
  logic [CNT_W-1:0]  r_lowCount;
  logic [CNT_W-1:0]  w_countNext;
  logic              w_capture;
  logic              w_relatch;
  logic              w_commit;

  target_t           r_target;
  logic [7:0]        r_wrData;
  logic              r_weHighSeen;
  logic [7:0]        r_td;
  logic [7:0]        r_tc;
  logic              r_tdStrobe;
  logic              r_tcStrobe;
  logic              r_oe;
  logic [7:0]        r_dout;

  assign w_syncIn = {i_ti_a, i_ti_d_in, i_ti_memen_n, i_ti_we_n, i_ti_dbin};

  tipi_sync #(
    .W(SYNC_W)
  ) u_sync (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_async  (w_syncIn),
    .o_sync   (w_syncOut)
  );

  assign {w_addr, w_data, w_memen_n, w_we_n, w_dbin} = w_syncOut;

  assign w_hitW = i_cru_en && !w_memen_n && ((w_addr == TD_ADDR) || (w_addr == TC_ADDR));
  assign w_hitR = i_cru_en && !w_memen_n && w_dbin &&
                  ((w_addr == RD_ADDR) || (w_addr == RC_ADDR));

  assign w_addrTarget = (w_addr == TD_ADDR) ? TGT_TD : TGT_TC;
  assign w_tgtAddr    = (r_target == TGT_TD) ? TD_ADDR : TC_ADDR;

  // A write already in progress when reset releases must not be picked up,
  // so counting waits until we_n has been seen inactive at least once.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = '0;
    w_capture   = 1'b0;
    w_relatch   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hitW && !w_we_n && r_weHighSeen) begin
          if (r_lowCount == CNT_W'(FILTER)) begin
            w_stateNext = ARMED;
            w_capture   = 1'b1;
          end else begin
            w_countNext = r_lowCount + 1'b1;
          end
        end
      end
      ARMED: begin
        if (!i_cru_en) begin
          w_stateNext = IDLE;
        end else if (w_we_n) begin
          w_stateNext = COMMIT;
        end else if (w_addr != w_tgtAddr) begin
          w_stateNext = IDLE;
        end else begin
          w_relatch = 1'b1;
        end
      end
      COMMIT: begin
        w_stateNext = WAIT;
      end
      WAIT: begin
        if (w_memen_n || (w_addr != w_tgtAddr)) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign w_commit = (r_state == ARMED) && (w_stateNext == COMMIT);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_lowCount   <= '0;
      r_target     <= TGT_TD;
      r_wrData     <= 8'h00;
      r_weHighSeen <= 1'b0;
      r_td         <= 8'h00;
      r_tc         <= 8'h00;
      r_tdStrobe   <= 1'b0;
      r_tcStrobe   <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_lowCount   <= w_countNext;
      r_weHighSeen <= r_weHighSeen | w_we_n;
      if (w_capture) begin
        r_target <= w_addrTarget;
        r_wrData <= w_data;
      end else if (w_relatch) begin
        r_wrData <= w_data;
      end
      // Register and strobe change together on the ARMED->COMMIT edge.
      r_tdStrobe <= w_commit && (r_target == TGT_TD);
      r_tcStrobe <= w_commit && (r_target == TGT_TC);
      if (w_commit && (r_target == TGT_TD)) begin
        r_td <= r_wrData;
      end
      if (w_commit && (r_target == TGT_TC)) begin
        r_tc <= r_wrData;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_oe   <= 1'b0;
      r_dout <= 8'h00;
    end else begin
      r_oe   <= w_hitR;
      r_dout <= w_hitR ? ((w_addr == RD_ADDR) ? i_rd : i_rc) : 8'h00;
    end
  end

  assign o_td        = r_td;
  assign o_tc        = r_tc;
  assign o_td_strobe = r_tdStrobe;
  assign o_tc_strobe = r_tcStrobe;
  assign o_ti_d_oe   = r_oe;
  assign o_ti_d_out  = r_dout;

endmodule

// File: tb/tb_tipi_ti_bus_regs.sv
// Testbench for tipi_ti_bus_regs: vector table plus hand-written timing sequences,
// with a scoreboard queue drained by a monitor on strobes and read enables.
`timescale 1ns/1ps
module tb_tipi_ti_bus_regs;

  localparam int KIND_TD = 0;
  localparam int KIND_TC = 1;
  localparam int KIND_RD = 2;

  logic        clock = 1'b0;
  logic        resetN;
  logic [15:0] tiA;
  logic [7:0]  tiDIn;
  logic [7:0]  tiDOut;
  logic        tiDOe;
  logic        tiMemenN;
  logic        tiWeN;
  logic        tiDbin;
  logic        cruEn;
  logic [7:0]  regRd;
  logic [7:0]  regRc;
  logic [7:0]  regTd;
  logic [7:0]  regTc;
  logic        tdStrobe;
  logic        tcStrobe;

  always #10 clock = ~clock;

  tipi_ti_bus_regs dut (
    .i_clk       (clock),
    .i_reset_n   (resetN),
    .i_ti_a      (tiA),
    .i_ti_d_in   (tiDIn),
    .o_ti_d_out  (tiDOut),
    .o_ti_d_oe   (tiDOe),
    .i_ti_memen_n(tiMemenN),
    .i_ti_we_n   (tiWeN),
    .i_ti_dbin   (tiDbin),
    .i_cru_en    (cruEn),
    .i_rd        (regRd),
    .i_rc        (regRc),
    .o_td        (regTd),
    .o_tc        (regTc),
    .o_td_strobe (tdStrobe),
    .o_tc_strobe (tcStrobe)
  );

  typedef struct {
    bit          isWrite;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          cru;
    int          lowCycles;
    bit          expEvent;
    logic [7:0]  expTd;
    logic [7:0]  expTc;
    logic [7:0]  expRead;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] value;
  } exp_t;

  exp_t sbQueue[$];
  int   checkCount = 0;
  int   passCount  = 0;
  logic prevTdStrobe = 1'b0;
  logic prevTcStrobe = 1'b0;
  logic prevOe       = 1'b0;
  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pushExp(input int kind, input logic [7:0] value);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    tiA   = v.addr;
    cruEn = v.cru;
    if (v.isWrite) begin
      if (v.expEvent) pushExp((v.addr == 16'h5FFF) ? KIND_TD : KIND_TC, v.data);
      tiDIn    = v.data;
      tiMemenN = 1'b0;
      step(2);
      tiWeN = 1'b0;
      step(v.lowCycles);
      tiWeN = 1'b1;
      step(2);
      tiMemenN = 1'b1;
      step(8);
    end else begin
      if (v.expEvent) pushExp(KIND_RD, v.expRead);
      tiMemenN = 1'b0;
      tiDbin   = 1'b1;
      step(6);
      tiMemenN = 1'b1;
      tiDbin   = 1'b0;
      step(6);
    end
  endtask

  // Scoreboard drain: every strobe or rising read enable must match the queue head.
  always @(negedge clock) begin
    if (tdStrobe) begin
      if (prevTdStrobe) checkOutput("tdStrobeWidth", {7'd0, tdStrobe}, 8'h00);
      else if (sbQueue.size() != 0 && sbQueue[0].kind == KIND_TD) begin
        checkOutput("tdCommitData", regTd, sbQueue[0].value);
        void'(sbQueue.pop_front());
      end else checkOutput("tdStrobeUnexpected", {7'd0, tdStrobe}, 8'h00);
    end
    if (tcStrobe) begin
      if (prevTcStrobe) checkOutput("tcStrobeWidth", {7'd0, tcStrobe}, 8'h00);
      else if (sbQueue.size() != 0 && sbQueue[0].kind == KIND_TC) begin
        checkOutput("tcCommitData", regTc, sbQueue[0].value);
        void'(sbQueue.pop_front());
      end else checkOutput("tcStrobeUnexpected", {7'd0, tcStrobe}, 8'h00);
    end
    if (tiDOe && !prevOe) begin
      if (sbQueue.size() != 0 && sbQueue[0].kind == KIND_RD) begin
        checkOutput("readData", tiDOut, sbQueue[0].value);
        void'(sbQueue.pop_front());
      end else checkOutput("readOeUnexpected", {7'd0, tiDOe}, 8'h00);
    end
    prevTdStrobe <= tdStrobe;
    prevTcStrobe <= tcStrobe;
    prevOe       <= tiDOe;
  end

  // Main sequence: reset, vector table, then multi-cycle corner cases.
  initial begin
    vec_t v;
    resetN   = 1'b0;
    tiA      = 16'h0000;
    tiDIn    = 8'h00;
    tiMemenN = 1'b1;
    tiWeN    = 1'b1;
    tiDbin   = 1'b0;
    cruEn    = 1'b1;
    regRd    = 8'h5A;
    regRc    = 8'hC3;
    step(3);
    checkOutput("resetTd", regTd, 8'h00);
    checkOutput("resetTc", regTc, 8'h00);
    checkOutput("resetDout", tiDOut, 8'h00);
    checkOutput("resetOe", {7'd0, tiDOe}, 8'h00);
    checkOutput("resetStrobes", {6'd0, tdStrobe, tcStrobe}, 8'h00);
    resetN = 1'b1;
    step(4);

    vecs[0]  = '{1, 16'h5FFF, 8'hFF, 1, 1,  0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1, 16'h5FFF, 8'h77, 1, 2,  0, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1, 16'h5FFF, 8'hA5, 1, 12, 1, 8'hA5, 8'h00, 8'h00};
    vecs[3]  = '{1, 16'h5FFD, 8'h3C, 0, 12, 0, 8'hA5, 8'h00, 8'h00};
    vecs[4]  = '{1, 16'h5FFD, 8'h3C, 1, 12, 1, 8'hA5, 8'h3C, 8'h00};
    vecs[5]  = '{1, 16'h5FFF, 8'h66, 1, 3,  1, 8'h66, 8'h3C, 8'h00};
    vecs[6]  = '{1, 16'h5FFB, 8'h12, 1, 12, 0, 8'h66, 8'h3C, 8'h00};
    vecs[7]  = '{0, 16'h5FFB, 8'h00, 1, 0,  1, 8'h66, 8'h3C, 8'h5A};
    vecs[8]  = '{0, 16'h5FF9, 8'h00, 1, 0,  1, 8'h66, 8'h3C, 8'hC3};
    vecs[9]  = '{0, 16'h5FFB, 8'h00, 0, 0,  0, 8'h66, 8'h3C, 8'h00};
    vecs[10] = '{0, 16'h5FFF, 8'h00, 1, 0,  0, 8'h66, 8'h3C, 8'h00};
    vecs[11] = '{1, 16'h5FFF, 8'hA5, 1, 12, 1, 8'hA5, 8'h3C, 8'h00};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d td", i), regTd, vecs[i].expTd);
      checkOutput($sformatf("vec%0d tc", i), regTc, vecs[i].expTc);
      checkOutput($sformatf("vec%0d sbDrained", i), 8'(sbQueue.size()), 8'h00);
      checkOutput($sformatf("vec%0d oeIdle", i), {7'd0, tiDOe}, 8'h00);
    end

    // Commit latency: strobe and TC update in the third cycle after we_n rises.
    cruEn = 1'b1;
    pushExp(KIND_TC, 8'hC7);
    tiA = 16'h5FFD; tiDIn = 8'hC7; tiMemenN = 1'b0;
    step(2);
    tiWeN = 1'b0;
    step(6);
    tiWeN = 1'b1;
    step(1); checkOutput("tcStrobeLat1", {7'd0, tcStrobe}, 8'h00);
    step(1); checkOutput("tcStrobeLat2", {7'd0, tcStrobe}, 8'h00);
    step(1); checkOutput("tcStrobeLat3", {7'd0, tcStrobe}, 8'h01);
    checkOutput("tcLat3", regTc, 8'hC7);
    checkOutput("tdUnchanged", regTd, 8'hA5);
    step(1); checkOutput("tcStrobeLat4", {7'd0, tcStrobe}, 8'h00);
    tiMemenN = 1'b1;
    step(8);

    // Read latency, live RD update, and release latency.
    pushExp(KIND_RD, 8'h5A);
    tiA = 16'h5FFB; tiMemenN = 1'b0; tiDbin = 1'b1;
    step(1); checkOutput("oeLat1", {7'd0, tiDOe}, 8'h00);
    step(1); checkOutput("oeLat2", {7'd0, tiDOe}, 8'h00);
    step(1); checkOutput("oeLat3", {7'd0, tiDOe}, 8'h01);
    checkOutput("doutLat3", tiDOut, 8'h5A);
    regRd = 8'h5B;
    step(1); checkOutput("doutRdChange", tiDOut, 8'h5B);
    tiMemenN = 1'b1; tiDbin = 1'b0;
    step(1); checkOutput("oeRel1", {7'd0, tiDOe}, 8'h01);
    step(1); checkOutput("oeRel2", {7'd0, tiDOe}, 8'h01);
    step(1); checkOutput("oeRel3", {7'd0, tiDOe}, 8'h00);
    checkOutput("doutRel3", tiDOut, 8'h00);
    regRd = 8'h5A;
    step(4);

    // Data changes while we_n is low: the last latched value wins.
    pushExp(KIND_TD, 8'h22);
    tiA = 16'h5FFF; tiDIn = 8'h11; tiMemenN = 1'b0;
    step(2);
    tiWeN = 1'b0;
    step(6);
    tiDIn = 8'h22;
    step(3);
    tiWeN = 1'b1;
    step(2);
    tiMemenN = 1'b1;
    step(8);
    checkOutput("dataChangeTd", regTd, 8'h22);

    // Back-to-back TD then TC with a single idle clock between bus cycles.
    pushExp(KIND_TD, 8'h01);
    pushExp(KIND_TC, 8'h02);
    tiA = 16'h5FFF; tiDIn = 8'h01; tiMemenN = 1'b0;
    step(2);
    tiWeN = 1'b0;
    step(6);
    tiWeN = 1'b1; tiMemenN = 1'b1;
    step(1);
    tiA = 16'h5FFD; tiDIn = 8'h02; tiMemenN = 1'b0;
    step(2);
    tiWeN = 1'b0;
    step(6);
    tiWeN = 1'b1; tiMemenN = 1'b1;
    step(8);
    checkOutput("b2bTd", regTd, 8'h01);
    checkOutput("b2bTc", regTc, 8'h02);
    checkOutput("b2bDrained", 8'(sbQueue.size()), 8'h00);

    // Reset while ARMED: the interrupted write is dropped.
    tiA = 16'h5FFF; tiDIn = 8'h99; tiMemenN = 1'b0;
    step(2);
    tiWeN = 1'b0;
    step(6);
    resetN = 1'b0;
    step(1);
    checkOutput("midResetTd", regTd, 8'h00);
    checkOutput("midResetTc", regTc, 8'h00);
    checkOutput("midResetDout", tiDOut, 8'h00);
    checkOutput("midResetFlags", {5'd0, tiDOe, tdStrobe, tcStrobe}, 8'h00);
    resetN = 1'b1;
    step(3);
    tiWeN = 1'b1;
    step(4);
    tiMemenN = 1'b1;
    step(6);
    checkOutput("afterResetTd", regTd, 8'h00);
    checkOutput("afterResetTc", regTc, 8'h00);

    v = '{1, 16'h5FFF, 8'h5E, 1, 12, 1, 8'h5E, 8'h00, 8'h00};
    applyStimulus(v);
    checkOutput("postResetTd", regTd, v.expTd);
    checkOutput("postResetTc", regTc, v.expTc);
    checkOutput("finalDrained", 8'(sbQueue.size()), 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
